// File: rtl/matrix_spi_driver.sv
// Serialises 8x8 game frames to a MAX7219-style controller over a 3-wire link.
// Optional build macro DEAD_INVERT_EN: frames latched with dead_i=1 are sent bitwise inverted.
module matrix_spi_driver #(
  parameter int         GS        = 8,
  parameter int         CLK_DIV   = 4,
  parameter logic [3:0] INTENSITY = 4'h8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [GS*GS-1:0]   matrix_i,
  input  logic               d_act_i,
  input  logic               dead_i,
  output logic               spi_clk_o,
  output logic               spi_mosi_o,
  output logic               spi_cs_o,
  output logic               busy_o,
  output logic               e_act_o
);

  typedef enum logic [1:0] {INIT = 2'd0, IDLE = 2'd1, SHIFT = 2'd2, GAP = 2'd3} state_t;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  state_t             state_reg, state_next;
  logic [2:0]         word_reg, word_next;
  logic [3:0]         bit_reg, bit_next;
  logic               phase_reg, phase_next;
  logic [DIV_W-1:0]   div_reg, div_next;
  logic               init_mode_reg, init_mode_next;
  logic [GS*GS-1:0]   frame_reg, frame_next;
  logic               invert_next;
  logic               sclk_next, mosi_next, cs_next, busy_next, e_act_next;
  logic [15:0]        frame_word [8];
  logic [15:0]        tx_word;
  logic [2:0]         last_word;

`ifdef DEAD_INVERT_EN
  logic dead_reg, dead_next;
  assign invert_next = dead_next;
`else
  logic unused_dead;
  assign invert_next = 1'b0;
  assign unused_dead = dead_i;
`endif

  function automatic logic [15:0] init_word(input logic [2:0] idx);
    case (idx)
      3'd0:    init_word = 16'h0C01;
      3'd1:    init_word = 16'h0900;
      3'd2:    init_word = {12'h0A0, INTENSITY};
      3'd3:    init_word = 16'h0B07;
      default: init_word = 16'h0F00;
    endcase
  endfunction

  // Word r addresses digit register r+1 and carries row r of the frame.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_row
      assign frame_word[gi] = {4'h0, 4'(gi + 1), frame_next[gi*GS +: 8] ^ {8{invert_next}}};
    end
  endgenerate

  assign tx_word   = init_mode_next ? init_word(word_next) : frame_word[word_next];
  assign last_word = init_mode_reg ? 3'd4 : 3'd7;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg     <= INIT;
      word_reg      <= 3'd0;
      bit_reg       <= 4'd15;
      phase_reg     <= 1'b0;
      div_reg       <= '0;
      init_mode_reg <= 1'b1;
      frame_reg     <= '0;
`ifdef DEAD_INVERT_EN
      dead_reg      <= 1'b0;
`endif
      spi_clk_o     <= 1'b0;
      spi_mosi_o    <= 1'b0;
      spi_cs_o      <= 1'b1;
      busy_o        <= 1'b0;
      e_act_o       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      word_reg      <= word_next;
      bit_reg       <= bit_next;
      phase_reg     <= phase_next;
      div_reg       <= div_next;
      init_mode_reg <= init_mode_next;
      frame_reg     <= frame_next;
`ifdef DEAD_INVERT_EN
      dead_reg      <= dead_next;
`endif
      spi_clk_o     <= sclk_next;
      spi_mosi_o    <= mosi_next;
      spi_cs_o      <= cs_next;
      busy_o        <= busy_next;
      e_act_o       <= e_act_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    word_next      = word_reg;
    bit_next       = bit_reg;
    phase_next     = phase_reg;
    div_next       = div_reg;
    init_mode_next = init_mode_reg;
    frame_next     = frame_reg;
`ifdef DEAD_INVERT_EN
    dead_next      = dead_reg;
`endif
    case (state_reg)
      INIT: begin
        state_next     = SHIFT;
        init_mode_next = 1'b1;
        word_next      = 3'd0;
        bit_next       = 4'd15;
        phase_next     = 1'b0;
        div_next       = '0;
      end
      IDLE: begin
        if (d_act_i) begin
          state_next     = SHIFT;
          init_mode_next = 1'b0;
          frame_next     = matrix_i;
`ifdef DEAD_INVERT_EN
          dead_next      = dead_i;
`endif
          word_next      = 3'd0;
          bit_next       = 4'd15;
          phase_next     = 1'b0;
          div_next       = '0;
        end
      end
      SHIFT: begin
        if (div_reg != DIV_LAST) begin
          div_next = div_reg + 1'b1;
        end else begin
          div_next = '0;
          if (!phase_reg) begin
            phase_next = 1'b1;
          end else if (bit_reg == 4'd0) begin
            phase_next = 1'b0;
            state_next = GAP;
          end else begin
            phase_next = 1'b0;
            bit_next   = bit_reg - 4'd1;
          end
        end
      end
      GAP: begin
        if (div_reg != DIV_LAST) begin
          div_next = div_reg + 1'b1;
        end else begin
          div_next = '0;
          if (word_reg == last_word) begin
            state_next = IDLE;
          end else begin
            state_next = SHIFT;
            word_next  = word_reg + 3'd1;
            bit_next   = 4'd15;
          end
        end
      end
      default: state_next = INIT;
    endcase
  end

  // Outputs are computed from the next state so that every port is a flop.
  always_comb begin
    sclk_next  = 1'b0;
    cs_next    = 1'b1;
    mosi_next  = spi_mosi_o;
    busy_next  = (state_next != IDLE);
    e_act_next = 1'b0;
    if (state_next == SHIFT) begin
      sclk_next = phase_next;
      cs_next   = 1'b0;
      mosi_next = tx_word[bit_next];
    end
    if (state_reg == GAP && state_next == IDLE && !init_mode_reg)
      e_act_next = 1'b1;
  end

endmodule

// File: tb/tb_matrix_spi_driver.sv
// Scoreboard bench for matrix_spi_driver: decodes the serial link and checks words and timing.
module tb_matrix_spi_driver;

  localparam int CD = 2;
  localparam logic [3:0] INT_VAL = 4'h8;
  localparam int WORD_CYC = 33 * CD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] matrix = '0;
  logic        d_act = 1'b0;
  logic        dead = 1'b0;
  logic        spi_clk, spi_mosi, spi_cs, busy, e_act;

  int pass_cnt = 0;
  int chk_cnt = 0;

  matrix_spi_driver #(.GS(8), .CLK_DIV(CD), .INTENSITY(INT_VAL)) dut (
    .clk_i(clk), .reset_i(reset), .matrix_i(matrix), .d_act_i(d_act), .dead_i(dead),
    .spi_clk_o(spi_clk), .spi_mosi_o(spi_mosi), .spi_cs_o(spi_cs),
    .busy_o(busy), .e_act_o(e_act)
  );

  always #5 clk = ~clk;

  // Link monitor: timestamps events and decodes each CS-low window into a word.
  int          cyc = 0;
  logic        p_cs = 1'b1, p_sclk = 1'b0, p_busy = 1'b0, p_mosi = 1'b0, p_rst = 1'b1;
  int          mon_bits = 0;
  logic [15:0] sh = '0;
  int          hi_run = 0;
  int          viol = 0;
  int          cs_fall_q[$], eact_q[$], acc_q[$], busy_fall_q[$], rst_fall_q[$];
  logic [15:0] rx_q[$];
  logic [15:0] exp_q[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!spi_cs && p_cs) begin
      cs_fall_q.push_back(cyc);
      mon_bits <= 0;
    end
    if (!spi_cs && spi_clk && !p_sclk) begin
      sh <= {sh[14:0], spi_mosi};
      mon_bits <= mon_bits + 1;
    end
    if (spi_cs && !p_cs) rx_q.push_back((mon_bits == 16) ? sh : 16'hxxxx);
    if (e_act) eact_q.push_back(cyc);
    if (d_act && !busy && !reset) acc_q.push_back(cyc);
    if (p_busy && !busy) busy_fall_q.push_back(cyc);
    if (p_rst && !reset) rst_fall_q.push_back(cyc);
    if (spi_clk && (spi_mosi !== p_mosi)) viol <= viol + 1;
    if (spi_clk && spi_cs) viol <= viol + 1;
    if (p_sclk && !spi_clk && !reset && hi_run != CD) viol <= viol + 1;
    hi_run <= spi_clk ? hi_run + 1 : 0;
    p_cs <= spi_cs; p_sclk <= spi_clk; p_busy <= busy; p_mosi <= spi_mosi; p_rst <= reset;
  end

  task automatic clear_mon();
    cs_fall_q.delete(); eact_q.delete(); acc_q.delete();
    busy_fall_q.delete(); rst_fall_q.delete(); rx_q.delete(); exp_q.delete();
  endtask

  task automatic push_frame(input logic [63:0] m, input logic inv);
    for (int r = 0; r < 8; r++) exp_q.push_back({4'h0, 4'(r + 1), m[r*8 +: 8] ^ {8{inv}}});
  endtask

  task automatic push_init();
    exp_q.push_back(16'h0C01); exp_q.push_back(16'h0900);
    exp_q.push_back({12'h0A0, INT_VAL}); exp_q.push_back(16'h0B07); exp_q.push_back(16'h0F00);
  endtask

  task automatic wait_busy_falls(input int n, input string name);
    for (int i = 0; i < 30 * 8 * WORD_CYC && busy_fall_q.size() < n; i++) begin
      @(posedge clk); #1;
    end
    chk_cnt++;
    if (busy_fall_q.size() < n) $display("FAIL %s timeout: busy falls=%0d need %0d", name, busy_fall_q.size(), n);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++; if (spi_cs !== 1'b1) $display("FAIL reset_cs got %b want 1", spi_cs); else pass_cnt++;
    chk_cnt++; if (spi_clk !== 1'b0) $display("FAIL reset_sclk got %b want 0", spi_clk); else pass_cnt++;
    chk_cnt++; if (spi_mosi !== 1'b0) $display("FAIL reset_mosi got %b want 0", spi_mosi); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (e_act !== 1'b0) $display("FAIL reset_eact got %b want 0", e_act); else pass_cnt++;
    $display("reset: cs=%b sclk=%b busy=%b e_act=%b", spi_cs, spi_clk, busy, e_act);
  endtask

  task automatic test_init(input string name);
    logic [15:0] e, g;
    clear_mon();
    push_init();
    reset = 1'b0;
    wait_busy_falls(1, name);
    repeat (10) @(posedge clk);
    #1;
    chk_cnt++;
    if (cs_fall_q[0] - rst_fall_q[0] != 1)
      $display("FAIL %s_first_cs got %0d want 1 cycle after release", name, cs_fall_q[0] - rst_fall_q[0]);
    else pass_cnt++;
    chk_cnt++;
    if (busy_fall_q[0] - cs_fall_q[0] != 5 * WORD_CYC)
      $display("FAIL %s_busy_fall got %0d want %0d", name, busy_fall_q[0] - cs_fall_q[0], 5 * WORD_CYC);
    else pass_cnt++;
    chk_cnt++;
    if (rx_q.size() != 5) $display("FAIL %s_word_count got %0d want 5", name, rx_q.size()); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (rx_q.size() > 0) ? rx_q.pop_front() : 16'hxxxx;
      chk_cnt++;
      if (g !== e) $display("FAIL %s_word got %h want %h", name, g, e); else pass_cnt++;
      $display("%s word: got %h want %h", name, g, e);
    end
    chk_cnt++;
    if (eact_q.size() != 0) $display("FAIL %s_no_eact got %0d pulses want 0", name, eact_q.size()); else pass_cnt++;
  endtask

  task automatic test_single_frame();
    logic [63:0] m;
    logic [15:0] e, g;
    for (int r = 0; r < 8; r++) m[r*8 +: 8] = 8'h01 << r;
    clear_mon();
    push_frame(m, 1'b0);
    matrix = m; d_act = 1'b1;
    @(posedge clk); #1;
    d_act = 1'b0;
    wait_busy_falls(1, "single");
    repeat (10) @(posedge clk);
    #1;
    chk_cnt++;
    if (cs_fall_q[0] - acc_q[0] != 1) $display("FAIL single_cs_fall got %0d want 1", cs_fall_q[0] - acc_q[0]); else pass_cnt++;
    chk_cnt++;
    if (eact_q.size() != 1) $display("FAIL single_eact_count got %0d want 1", eact_q.size()); else pass_cnt++;
    chk_cnt++;
    if (eact_q[0] - acc_q[0] != 8 * WORD_CYC + 1)
      $display("FAIL single_eact_time got %0d want %0d", eact_q[0] - acc_q[0], 8 * WORD_CYC + 1);
    else pass_cnt++;
    chk_cnt++;
    if (rx_q.size() != 8) $display("FAIL single_word_count got %0d want 8", rx_q.size()); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (rx_q.size() > 0) ? rx_q.pop_front() : 16'hxxxx;
      chk_cnt++;
      if (g !== e) $display("FAIL single_word got %h want %h", g, e); else pass_cnt++;
      $display("single word: got %h want %h", g, e);
    end
  endtask

  task automatic test_busy_blocking();
    logic [63:0] a;
    logic [15:0] e, g;
    a = {$urandom, $urandom};
    clear_mon();
    push_frame(a, 1'b0);
    matrix = a; d_act = 1'b1;
    @(posedge clk); #1;
    d_act = 1'b0;
    for (int i = 0; i < 8 * WORD_CYC && cs_fall_q.size() < 3; i++) begin
      @(posedge clk); #1;
    end
    matrix = ~a; d_act = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    d_act = 1'b0; matrix = {$urandom, $urandom};
    wait_busy_falls(1, "blocking");
    repeat (20) @(posedge clk);
    #1;
    chk_cnt++;
    if (cs_fall_q.size() != 8) $display("FAIL blocking_cs_windows got %0d want 8", cs_fall_q.size()); else pass_cnt++;
    chk_cnt++;
    if (eact_q.size() != 1) $display("FAIL blocking_eact_count got %0d want 1", eact_q.size()); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (rx_q.size() > 0) ? rx_q.pop_front() : 16'hxxxx;
      chk_cnt++;
      if (g !== e) $display("FAIL blocking_word got %h want %h", g, e); else pass_cnt++;
      $display("blocking word: got %h want %h", g, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] m [3];
    logic [15:0] e, g;
    logic found;
    for (int k = 0; k < 3; k++) m[k] = {$urandom, $urandom};
    clear_mon();
    for (int k = 0; k < 3; k++) push_frame(m[k], 1'b0);
    matrix = m[0]; d_act = 1'b1;
    for (int k = 0; k < 3; k++) begin
      found = 1'b0;
      for (int i = 0; i < 10 * WORD_CYC && !found; i++) begin
        @(negedge clk);
        found = e_act;
      end
      chk_cnt++;
      if (found !== 1'b1) $display("FAIL b2b_eact_timeout frame %0d got none want pulse", k); else pass_cnt++;
      if (k < 2) matrix = m[k+1];
      else d_act = 1'b0;
    end
    repeat (20) @(posedge clk);
    #1;
    chk_cnt++;
    if (eact_q.size() != 3) $display("FAIL b2b_eact_count got %0d want 3", eact_q.size()); else pass_cnt++;
    chk_cnt++;
    if (cs_fall_q.size() != 24) $display("FAIL b2b_cs_windows got %0d want 24", cs_fall_q.size()); else pass_cnt++;
    for (int k = 1; k < 3; k++) begin
      chk_cnt++;
      if (eact_q[k] - eact_q[k-1] != 8 * WORD_CYC + 1)
        $display("FAIL b2b_period got %0d want %0d", eact_q[k] - eact_q[k-1], 8 * WORD_CYC + 1);
      else pass_cnt++;
      chk_cnt++;
      if (cs_fall_q[8*k] - eact_q[k-1] != 1)
        $display("FAIL b2b_restart got %0d want 1", cs_fall_q[8*k] - eact_q[k-1]);
      else pass_cnt++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (rx_q.size() > 0) ? rx_q.pop_front() : 16'hxxxx;
      chk_cnt++;
      if (g !== e) $display("FAIL b2b_word got %h want %h", g, e); else pass_cnt++;
      $display("b2b word: got %h want %h", g, e);
    end
  endtask

  task automatic test_dead();
    logic [15:0] e, g;
    logic inv;
`ifdef DEAD_INVERT_EN
    inv = 1'b1;
`else
    inv = 1'b0;
`endif
    clear_mon();
    push_frame(64'h0, inv);
    push_frame(64'h0, 1'b0);
    matrix = '0;
    for (int f = 0; f < 2; f++) begin
      dead = (f == 0); d_act = 1'b1;
      @(posedge clk); #1;
      d_act = 1'b0; dead = 1'b0;
      wait_busy_falls(f + 1, "dead");
      repeat (3) @(posedge clk);
      #1;
    end
    chk_cnt++;
    if (rx_q.size() != 16) $display("FAIL dead_word_count got %0d want 16", rx_q.size()); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (rx_q.size() > 0) ? rx_q.pop_front() : 16'hxxxx;
      chk_cnt++;
      if (g !== e) $display("FAIL dead_word got %h want %h", g, e); else pass_cnt++;
      $display("dead word: got %h want %h", g, e);
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    matrix = {$urandom, $urandom}; d_act = 1'b1;
    @(posedge clk); #1;
    d_act = 1'b0;
    for (int i = 0; i < 8 * WORD_CYC && !(cs_fall_q.size() == 5 && mon_bits == 9); i++) begin
      @(posedge clk); #1;
    end
    chk_cnt++;
    if (mon_bits != 9) $display("FAIL midrst_reach got bits=%0d want 9", mon_bits); else pass_cnt++;
    reset = 1'b1;
    @(posedge clk); #1;
    chk_cnt++; if (spi_cs !== 1'b1) $display("FAIL midrst_cs got %b want 1", spi_cs); else pass_cnt++;
    chk_cnt++; if (spi_clk !== 1'b0) $display("FAIL midrst_sclk got %b want 0", spi_clk); else pass_cnt++;
    chk_cnt++; if (e_act !== 1'b0) $display("FAIL midrst_eact got %b want 0", e_act); else pass_cnt++;
    $display("midrst: cs=%b sclk=%b e_act=%b", spi_cs, spi_clk, e_act);
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if (eact_q.size() != 0) $display("FAIL midrst_no_eact got %0d want 0", eact_q.size()); else pass_cnt++;
    test_init("reinit");
  endtask

  task automatic test_protocol();
    chk_cnt++;
    if (viol != 0) $display("FAIL protocol_violations got %0d want 0", viol); else pass_cnt++;
    $display("protocol: violations=%0d", viol);
  endtask

  initial begin
    test_reset();
    test_init("init");
    test_single_frame();
    test_busy_blocking();
    test_back_to_back();
    test_dead();
    test_reset_mid();
    test_protocol();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/matrix_spi_driver.md
# matrix_spi_driver

Downstream display stage for the 8×8 game: takes the flattened matrix and the data-active flag from the game-logic stage and serialises each frame to a MAX7219-style LED matrix controller over a 3-wire serial link. After every completed frame it emits a one-cycle `e_act_o` pulse, which is the step enable for the game-logic stage. This paces the game at the display refresh rate. On reset it first sends a fixed controller-initialisation sequence.

## Interface
- `GS`, 8: matrix edge length. 8 is the only legal value because the controller has 8 digit registers of 8 bits.
- `CLK_DIV`, 4: `clk_i` cycles per SCLK half-period. Must be ≥1.
- `INTENSITY`, 4'h8: value written to the intensity register (0x0A) during init.

- `clk_i`  in  1  system clock
- `reset_i`  in  1  synchronous, active-high reset
- `matrix_i`  in  GS*GS  flattened frame; bit `r*GS+b` is row r, column b
- `d_act_i`  in  1  frame data valid (level)
- `dead_i`  in  1  game-over flag
- `spi_clk_o`  out  1  serial clock, idle low
- `spi_mosi_o`  out  1  serial data, MSB first
- `spi_cs_o`  out  1  load/chip-select, active low
- `busy_o`  out  1  high while the init sequence or a frame is in progress
- `e_act_o`  out  1  one-cycle pulse when a frame completes

## Operation
- **States:** INIT, IDLE, SHIFT, GAP.
- **Reset:** all outputs are reset to 0 except `spi_cs_o`, which resets to 1. The word index is cleared and the FSM enters INIT.
- **INIT:** sends 5 words in this order: 0x0C01 (shutdown off), 0x0900 (no decode), 0x0A00|INTENSITY, 0x0B07 (scan limit 7), 0x0F00 (display test off). Then goes to IDLE.
  - `e_act_o` is never pulsed for the init sequence.
- **IDLE:**
  - If `d_act_i` is 1 in a cycle, the block latches `matrix_i` (and `dead_i`) into a frame register that cycle and starts the frame.
  - The frame is 8 words, row r = 0..7: word = {4'h0, 4'(r+1), frame[r*GS+7 : r*GS]}.
- **Word transfer (SHIFT):**
  - `spi_cs_o` is low for all 16 bits.
  - For each bit, `spi_mosi_o` is set, then `spi_clk_o` is low for CLK_DIV cycles and high for CLK_DIV cycles.
  - The receiver samples on the rising edge.
  - After bit 0's high phase: `spi_clk_o` goes to 0 and `spi_cs_o` goes to 1, and the FSM enters GAP.
- **GAP:** lasts CLK_DIV cycles with CS high; the rising edge of CS latches the word in the controller. The next word then starts, or, after the last word:
  - end of INIT → IDLE, no pulse;
  - end of a frame → IDLE with `e_act_o`=1 for exactly one cycle.
- **`busy_o`:** 1 in INIT, SHIFT and GAP; 0 in IDLE.
- **`d_act_i` while busy:** ignored, with no queuing. `matrix_i` changes mid-frame do not affect the frame in flight.
- **`d_act_i` held high:** back-to-back frames. The next frame starts in the cycle after the `e_act_o` pulse (the IDLE cycle carrying the pulse also samples `d_act_i`).
- **Reset mid-transfer:** `spi_cs_o`=1, `spi_clk_o`=0 and `e_act_o`=0 in the next cycle. The partial word is discarded and init restarts.

## Timing
- One word takes 33·CLK_DIV cycles: 32·CLK_DIV for the 16 bits plus CLK_DIV of GAP.
- **Frame accept** at IDLE cycle t:
  - `spi_cs_o` falls at t+1;
  - `e_act_o` is high at cycle t+1+8·33·CLK_DIV, which is 1057 for CLK_DIV=4.
- **Init:** the first CS fall is in the cycle after reset deasserts. IDLE is reached 5·33·CLK_DIV cycles later.
- `spi_mosi_o` changes only while `spi_clk_o` is low, at the start of each low phase.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- **`DEAD_INVERT_EN` defined:** when the latched `dead_i` is 1, all 8 data bytes of that frame are bitwise inverted (the screen shows the negative frame); `dead_i`=0 frames are unchanged.
- **`DEAD_INVERT_EN` undefined:** `dead_i` is unused and the data is sent as latched.
- Init words, timing and handshakes are identical in both builds.

## Test plan
- **Init sequence:** CLK_DIV=1, release reset, `d_act_i`=0.
  - Required: exactly 5 CS-low windows decoding 0x0C01, 0x0900, 0x0A08, 0x0B07, 0x0F00.
  - Required: `busy_o` falls at cycle 165, and `e_act_o` never pulses.
- **Single frame:** after init, `matrix_i` row r = 8'h01<<r, with a one-cycle `d_act_i`.
  - Required: words 0x0101, 0x0202, 0x0304 … 0x0880.
  - Required: one `e_act_o` pulse 8·33·CLK_DIV+1 cycles after accept.
- **Busy blocking:** pulse `d_act_i` and change `matrix_i` mid-frame.
  - Required: the frame in flight is unchanged.
  - Required: no second frame follows when `d_act_i` is low at the `e_act_o` pulse.
- **Continuous `d_act_i`=1:**
  - Required: CS falls in the cycle immediately after each `e_act_o` pulse.
  - Required: pulses are exactly 264·CLK_DIV+1 cycles apart.
- **Reset mid-frame:** assert `reset_i` during word 4, bit 7.
  - Required: CS=1 and SCLK=0 next cycle, no `e_act_o`.
  - Required: the init sequence restarts from 0x0C01.
- **`DEAD_INVERT_EN` build:** `dead_i`=1, all-zero matrix → 8 words with data 0xFF; with `dead_i`=0 → data 0x00.
